// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI target with on-chip pin synchronisers, all four CPOL/CPHA
// modes, back-to-back words inside one chip-select window, a one-entry TX
// holding buffer with ready/load handshake and a one-cycle RX valid strobe.
// Build option: define SPI_PERIPH_SCLK_FILTER_EN to add a two-cycle SCLK
// deglitch filter ahead of the edge detector (adds one cycle to SCLK paths).
module spi_peripheral #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic             IDLE_LVL = (CPOL != 0);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  typedef enum logic {IDLE, SHIFT} stateType;
  stateType state;

  logic [SYNC_STAGES-1:0] sclkSync, csSync, mosiSync;
  logic                   sclkS, csS, mosiS;
  logic                   sclkRef, sclkEdge, leadEdge, trailEdge;
  logic                   csPrev, csFall, csRise;
  logic                   samplePulse, shiftPulse, mosiQ;
  logic [WIDTH-1:0]       txShift, txBuf, rxShift;
  logic                   txFull, first, wordStart;
  logic [CNT_W-1:0]       bitCnt;

  // Bring the three asynchronous pins into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sclkSync <= {SYNC_STAGES{IDLE_LVL}};
      csSync   <= '1;
      mosiSync <= '0;
    end else begin
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], sclk};
      csSync   <= {csSync[SYNC_STAGES-2:0], cs_n};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclkS = sclkSync[SYNC_STAGES-1];
  assign csS   = csSync[SYNC_STAGES-1];
  assign mosiS = mosiSync[SYNC_STAGES-1];

`ifdef SPI_PERIPH_SCLK_FILTER_EN
  logic sclkHold;

  // Remember last cycle's synced sclk so a new level must persist two cycles
  always_ff @(posedge clk) begin
    if (reset) sclkHold <= IDLE_LVL;
    else       sclkHold <= sclkS;
  end

  assign sclkEdge = (sclkS == sclkHold) && (sclkS != sclkRef);
`else
  assign sclkEdge = (sclkS != sclkRef);
`endif

  // Track the last accepted sclk level; an edge is any change from it
  always_ff @(posedge clk) begin
    if (reset)         sclkRef <= IDLE_LVL;
    else if (sclkEdge) sclkRef <= sclkS;
  end

  assign leadEdge  = sclkEdge && (sclkS != IDLE_LVL);
  assign trailEdge = sclkEdge && (sclkS == IDLE_LVL);

  // Register mode-mapped sample/shift pulses together with the aligned mosi bit
  always_ff @(posedge clk) begin
    if (reset) begin
      samplePulse <= 1'b0;
      shiftPulse  <= 1'b0;
      mosiQ       <= 1'b0;
    end else begin
      samplePulse <= (CPHA == 0) ? leadEdge : trailEdge;
      shiftPulse  <= (CPHA == 0) ? trailEdge : leadEdge;
      mosiQ       <= mosiS;
    end
  end

  // Registered copy of synced cs_n for select/deselect detection
  always_ff @(posedge clk) begin
    if (reset) csPrev <= 1'b1;
    else       csPrev <= csS;
  end

  assign csFall    = csPrev && !csS;
  assign csRise    = !csPrev && csS;
  assign wordStart = ((state == IDLE) && csFall) ||
                     ((state == SHIFT) && !csRise && (bitCnt == FULL_CNT));
  assign tx_ready  = !txFull;

  // Transfer FSM, holding-buffer handshake and shift registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bitCnt      <= '0;
      first       <= 1'b0;
      txShift     <= '0;
      txBuf       <= '0;
      txFull      <= 1'b0;
      rxShift     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (wordStart) begin
        first  <= 1'b1;
        bitCnt <= '0;
        if (txFull) begin
          txShift <= txBuf;
          txFull  <= 1'b0;
        end else if (tx_load) begin
          txShift <= tx_data;
        end else begin
          txShift     <= '0;
          tx_underrun <= 1'b1;
        end
      end else if (tx_load && !txFull) begin
        txBuf  <= tx_data;
        txFull <= 1'b1;
      end

      case (state)
        IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          bitCnt  <= '0;
          if (csFall) begin
            state   <= SHIFT;
            miso_oe <= 1'b1;
          end
        end
        SHIFT: begin
          if (csRise) begin
            state   <= IDLE;
            bitCnt  <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end else begin
            miso    <= txShift[WIDTH-1];
            miso_oe <= 1'b1;
            if (bitCnt == FULL_CNT) begin
              rx_data  <= rxShift;
              rx_valid <= 1'b1;
            end else begin
              if (samplePulse) begin
                rxShift <= {rxShift[WIDTH-2:0], mosiQ};
                bitCnt  <= bitCnt + CNT_W'(1);
                if (CPHA == 0) first <= 1'b0;
              end
              if (shiftPulse) begin
                if (first) first   <= 1'b0;
                else       txShift <= {txShift[WIDTH-2:0], 1'b0};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed checks of spi_peripheral in all four SPI modes.
// Instance 0 is mode 0 / 8 bits; instances 1..3 are modes 1..3 / 16 bits.
module tb_spi_peripheral;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sclkPin, csPin, mosiPin, txLoad;
  logic [15:0] txData [4];
  wire  [3:0]  misoV, oeV, readyV, validV, underrunV;
  wire  [7:0]  rxData0;
  wire  [15:0] rxData1, rxData2, rxData3;

  int checks = 0;
  int errors = 0;
  int validCnt [4] = '{default: 0};
  int underrunCnt [4] = '{default: 0};

  always #5 clk = ~clk;

  spi_peripheral #(.WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .sclk(sclkPin[0]), .cs_n(csPin[0]), .mosi(mosiPin[0]),
    .miso(misoV[0]), .miso_oe(oeV[0]), .tx_data(txData[0][7:0]), .tx_load(txLoad[0]),
    .tx_ready(readyV[0]), .rx_data(rxData0), .rx_valid(validV[0]), .tx_underrun(underrunV[0]));

  spi_peripheral #(.WIDTH(16), .CPOL(0), .CPHA(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .sclk(sclkPin[1]), .cs_n(csPin[1]), .mosi(mosiPin[1]),
    .miso(misoV[1]), .miso_oe(oeV[1]), .tx_data(txData[1]), .tx_load(txLoad[1]),
    .tx_ready(readyV[1]), .rx_data(rxData1), .rx_valid(validV[1]), .tx_underrun(underrunV[1]));

  spi_peripheral #(.WIDTH(16), .CPOL(1), .CPHA(0), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .sclk(sclkPin[2]), .cs_n(csPin[2]), .mosi(mosiPin[2]),
    .miso(misoV[2]), .miso_oe(oeV[2]), .tx_data(txData[2]), .tx_load(txLoad[2]),
    .tx_ready(readyV[2]), .rx_data(rxData2), .rx_valid(validV[2]), .tx_underrun(underrunV[2]));

  spi_peripheral #(.WIDTH(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .reset(reset), .sclk(sclkPin[3]), .cs_n(csPin[3]), .mosi(mosiPin[3]),
    .miso(misoV[3]), .miso_oe(oeV[3]), .tx_data(txData[3]), .tx_load(txLoad[3]),
    .tx_ready(readyV[3]), .rx_data(rxData3), .rx_valid(validV[3]), .tx_underrun(underrunV[3]));

  // Count strobe cycles so pulse widths and pulse counts can be checked later
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (validV[i])    validCnt[i]++;
      if (underrunV[i]) underrunCnt[i]++;
    end
  end

  function automatic logic [15:0] getRx(input int idx);
    case (idx)
      0:       return {8'h00, rxData0};
      1:       return rxData1;
      2:       return rxData2;
      default: return rxData3;
    endcase
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic loadTx(input int idx, input logic [15:0] data);
    txData[idx] = data;
    txLoad[idx] = 1'b1;
    waitClk(1);
    txLoad[idx] = 1'b0;
    waitClk(1);
  endtask

  task automatic selectDev(input int idx);
    csPin[idx] = 1'b0;
    waitClk(HALF);
  endtask

  task automatic deselectDev(input int idx);
    waitClk(HALF);
    csPin[idx] = 1'b1;
    waitClk(HALF);
  endtask

  // Act as the SPI controller for nbits bits, MSB first, capturing MISO at each sample edge
  task automatic applyStimulus(input int idx, input bit cpol, input bit cpha, input int nbits,
                               input logic [15:0] mosiWord, output logic [15:0] misoWord);
    misoWord = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosiPin[idx] = mosiWord[i];
        waitClk(HALF);
        misoWord[i]  = misoV[idx];
        sclkPin[idx] = ~cpol;
        waitClk(HALF);
        sclkPin[idx] = cpol;
      end else begin
        sclkPin[idx] = ~cpol;
        mosiPin[idx] = mosiWord[i];
        waitClk(HALF);
        misoWord[i]  = misoV[idx];
        sclkPin[idx] = cpol;
        waitClk(HALF);
      end
    end
  endtask

  // Directed test sequence
  initial begin
    logic [15:0] misoWord;
    int          vBase, uBase, glitchExp;
    bit          cpolTab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit          cphaTab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    reset   = 1'b1;
    sclkPin = 4'b1100;
    csPin   = 4'hF;
    mosiPin = 4'h0;
    txLoad  = 4'h0;
    for (int i = 0; i < 4; i++) txData[i] = '0;
    waitClk(3);

    $display("[TB] reset values");
    checkOutput("rstMiso", {15'd0, misoV[0]}, 16'd0);
    checkOutput("rstMisoOe", {15'd0, oeV[0]}, 16'd0);
    checkOutput("rstTxReady", {15'd0, readyV[0]}, 16'd1);
    checkOutput("rstRxData", getRx(0), 16'h0000);
    checkOutput("rstRxValid", {15'd0, validV[0]}, 16'd0);
    checkOutput("rstUnderrun", {15'd0, underrunV[0]}, 16'd0);
    reset = 1'b0;
    waitClk(2);

    $display("[TB] mode 0 single word");
    vBase = validCnt[0];
    uBase = underrunCnt[0];
    loadTx(0, 16'h00A5);
    checkOutput("t1ReadyAfterLoad", {15'd0, readyV[0]}, 16'd0);
    selectDev(0);
    checkOutput("t1ReadyAfterStart", {15'd0, readyV[0]}, 16'd1);
    checkOutput("t1MisoOe", {15'd0, oeV[0]}, 16'd1);
    applyStimulus(0, 1'b0, 1'b0, 8, 16'h003C, misoWord);
    deselectDev(0);
    checkOutput("t1MisoStream", misoWord, 16'h00A5);
    checkOutput("t1RxData", getRx(0), 16'h003C);
    checkOutput("t1RxValidCycles", 16'(validCnt[0] - vBase), 16'd1);
    checkOutput("t1FollowOnUnderrun", 16'(underrunCnt[0] - uBase), 16'd1);
    checkOutput("t1MisoOeIdle", {15'd0, oeV[0]}, 16'd0);

    $display("[TB] modes 1..3 with 16-bit words");
    for (int d = 1; d < 4; d++) begin
      loadTx(d, 16'hBEEF);
      selectDev(d);
      applyStimulus(d, cpolTab[d], cphaTab[d], 16, 16'h1234, misoWord);
      deselectDev(d);
      checkOutput($sformatf("t2RxData%0d", d), getRx(d), 16'h1234);
      checkOutput($sformatf("t2MisoStream%0d", d), misoWord, 16'hBEEF);
    end

    $display("[TB] back-to-back words");
    vBase = validCnt[0];
    uBase = underrunCnt[0];
    loadTx(0, 16'h005A);
    selectDev(0);
    loadTx(0, 16'h0011);
    checkOutput("t3ReadyRefilled", {15'd0, readyV[0]}, 16'd0);
    applyStimulus(0, 1'b0, 1'b0, 8, 16'h00C3, misoWord);
    checkOutput("t3Word1Miso", misoWord, 16'h005A);
    checkOutput("t3Word1Rx", getRx(0), 16'h00C3);
    checkOutput("t3ReadyAfterWord1", {15'd0, readyV[0]}, 16'd1);
    applyStimulus(0, 1'b0, 1'b0, 8, 16'h0066, misoWord);
    waitClk(2);
    checkOutput("t3Word2Miso", misoWord, 16'h0011);
    checkOutput("t3Word2Rx", getRx(0), 16'h0066);
    checkOutput("t3TwoValidPulses", 16'(validCnt[0] - vBase), 16'd2);
    checkOutput("t3OneUnderrun", 16'(underrunCnt[0] - uBase), 16'd1);
    applyStimulus(0, 1'b0, 1'b0, 8, 16'h0099, misoWord);
    deselectDev(0);
    checkOutput("t3Word3Miso", misoWord, 16'h0000);
    checkOutput("t3Word3Rx", getRx(0), 16'h0099);

    $display("[TB] abort after 5 bits");
    loadTx(0, 16'h0077);
    vBase = validCnt[0];
    selectDev(0);
    applyStimulus(0, 1'b0, 1'b0, 5, 16'h0016, misoWord);
    deselectDev(0);
    checkOutput("t4NoValid", 16'(validCnt[0] - vBase), 16'd0);
    checkOutput("t4RxHeld", getRx(0), 16'h0099);
    checkOutput("t4MisoOeLow", {15'd0, oeV[0]}, 16'd0);
    checkOutput("t4MisoLow", {15'd0, misoV[0]}, 16'd0);
    loadTx(0, 16'h0042);
    selectDev(0);
    applyStimulus(0, 1'b0, 1'b0, 8, 16'h0081, misoWord);
    deselectDev(0);
    checkOutput("t4RxAfter", getRx(0), 16'h0081);
    checkOutput("t4MisoAfter", misoWord, 16'h0042);
    checkOutput("t4OneValid", 16'(validCnt[0] - vBase), 16'd1);

    $display("[TB] reset mid-word");
    loadTx(0, 16'h003C);
    selectDev(0);
    applyStimulus(0, 1'b0, 1'b0, 4, 16'h000A, misoWord);
    reset    = 1'b1;
    csPin[0] = 1'b1;
    waitClk(1);
    checkOutput("t5Miso", {15'd0, misoV[0]}, 16'd0);
    checkOutput("t5MisoOe", {15'd0, oeV[0]}, 16'd0);
    checkOutput("t5TxReady", {15'd0, readyV[0]}, 16'd1);
    checkOutput("t5RxData", getRx(0), 16'h0000);
    checkOutput("t5RxValid", {15'd0, validV[0]}, 16'd0);
    checkOutput("t5Underrun", {15'd0, underrunV[0]}, 16'd0);
    reset = 1'b0;
    waitClk(HALF);
    vBase = validCnt[0];
    loadTx(0, 16'h00E7);
    selectDev(0);
    applyStimulus(0, 1'b0, 1'b0, 8, 16'h005A, misoWord);
    deselectDev(0);
    checkOutput("t5RxAfter", getRx(0), 16'h005A);
    checkOutput("t5MisoAfter", misoWord, 16'h00E7);
    checkOutput("t5OneValid", 16'(validCnt[0] - vBase), 16'd1);

    $display("[TB] one-cycle sclk glitch");
`ifdef SPI_PERIPH_SCLK_FILTER_EN
    glitchExp = 3;
`else
    glitchExp = 4;
`endif
    loadTx(0, 16'h00F0);
    selectDev(0);
    applyStimulus(0, 1'b0, 1'b0, 3, 16'h0005, misoWord);
    waitClk(HALF);
    checkOutput("t6CntBefore", 16'(dut0.bitCnt), 16'd3);
    sclkPin[0] = 1'b1;
    waitClk(1);
    sclkPin[0] = 1'b0;
    waitClk(HALF);
    checkOutput("t6CntAfter", 16'(dut0.bitCnt), 16'(glitchExp));
    deselectDev(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
